// File: rtl/arb8_rr.sv
// Eight-way round-robin arbiter with grant hold and optional hold-time preemption.
// Grants, valid and index are all registered; handoff between owners costs no idle cycle.
module arb8_rr #(
    parameter int HOLD_MAX = 0
) (
    input  logic       CK,
    input  logic       CD,
    input  logic [7:0] REQ,
    output logic [7:0] GNT,
    output logic       GVLD,
    output logic [2:0] GIDX
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

    state_t     r_state;
    state_t     w_state_next;
    logic [2:0] r_ptr;
    logic [2:0] w_ptr_next;
    logic [7:0] r_hcnt;
    logic [7:0] w_hcnt_next;
    logic [7:0] r_gnt;
    logic [7:0] w_gnt_next;
    logic       r_gvld;
    logic       w_gvld_next;
    logic [2:0] r_gidx;
    logic [2:0] w_gidx_next;

    // The current owner is masked out of the candidate set; in IDLE r_gnt is zero so
    // nothing is masked, and on release the owner's bit is already low.
    logic [7:0] w_req_cand;
    logic [7:0] w_rot;
    logic [2:0] w_off;
    logic [2:0] w_win;
    logic       w_any;
    logic       w_own_req;
    logic       w_expired;
    logic [7:0] w_hcnt_inc;

    assign w_req_cand = REQ & ~r_gnt;
    assign w_any      = |w_req_cand;
    assign w_own_req  = REQ[r_gidx];
    assign w_hcnt_inc = (r_hcnt == 8'hFF) ? 8'hFF : r_hcnt + 8'd1;

    // Rotate the candidates so that bit 0 of w_rot is the requester at PTR.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rot
            assign w_rot[gi] = w_req_cand[r_ptr + 3'(gi)];
        end
    endgenerate

    always_comb begin
        w_off = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = 3'(k);
            end
        end
    end

    assign w_win = r_ptr + w_off;

    generate
        if (HOLD_MAX == 0) begin : g_no_preempt
            assign w_expired = 1'b0;
        end else begin : g_preempt
            assign w_expired = (r_hcnt >= HOLD_LIM);
        end
    endgenerate

    always_ff @(posedge CK) begin
        if (CD) begin
            r_state <= ST_IDLE;
            r_ptr   <= 3'd0;
            r_hcnt  <= 8'd0;
            r_gnt   <= 8'd0;
            r_gvld  <= 1'b0;
            r_gidx  <= 3'd0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
            r_hcnt  <= w_hcnt_next;
            r_gnt   <= w_gnt_next;
            r_gvld  <= w_gvld_next;
            r_gidx  <= w_gidx_next;
        end
    end

    always_comb begin
        logic do_grant;
        logic go_idle;

        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_hcnt_next  = r_hcnt;
        w_gnt_next   = r_gnt;
        w_gvld_next  = r_gvld;
        w_gidx_next  = r_gidx;
        do_grant     = 1'b0;
        go_idle      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                do_grant = w_any;
            end
            ST_BUSY: begin
                if (!w_own_req) begin
                    // Release wins over a coincident preemption.
                    do_grant = w_any;
                    go_idle  = !w_any;
                end else if (w_expired && w_any) begin
                    do_grant = 1'b1;
                end else begin
                    w_hcnt_next = w_hcnt_inc;
                end
            end
            default: begin
                go_idle = 1'b1;
            end
        endcase

        if (do_grant) begin
            w_state_next = ST_BUSY;
            w_gnt_next   = 8'b1 << w_win;
            w_gvld_next  = 1'b1;
            w_gidx_next  = w_win;
            w_hcnt_next  = 8'd1;
            w_ptr_next   = w_win + 3'd1;
        end else if (go_idle) begin
            w_state_next = ST_IDLE;
            w_gnt_next   = 8'd0;
            w_gvld_next  = 1'b0;
            w_hcnt_next  = 8'd0;
        end
    end

    assign GNT  = r_gnt;
    assign GVLD = r_gvld;
    assign GIDX = r_gidx;

endmodule
